cgra_mem_port_ctrl: RTL

Multi-channel, parametrised data-memory port controller between the CGRA reconfigurable-cell columns and OBI-style data bus masters, one channel per column. Each channel generates strided or indirect addresses, keeps up to MAX_OUT transactions in flight with in-order response tracking, and posts writes without stalling. It produces per-channel stall, combined across channels that execute one multi-column kernel.

---
 rtl/cgra_mem_port_ctrl_if.sv | 26 ++
 rtl/cgra_mem_port_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/cgra_mem_port_ctrl_if.sv
// Per-channel OBI-style data bus bundle between the CGRA memory port controller
// (master) and the data bus (slave).
interface cgra_mem_port_ctrl_if #(
   parameter int N_CH = 4,
   parameter int AW   = 32,
   parameter int DW   = 32
);
   logic [N_CH-1:0]             bus_req;
   logic [N_CH-1:0][AW-1:0]     bus_addr;
   logic [N_CH-1:0]             bus_we;
   logic [N_CH-1:0][DW/8-1:0]   bus_be;
   logic [N_CH-1:0][DW-1:0]     bus_wdata;
   logic [N_CH-1:0]             bus_gnt;
   logic [N_CH-1:0]             bus_rvalid;
   logic [N_CH-1:0][DW-1:0]     bus_rdata;

   modport master (
      output bus_req, bus_addr, bus_we, bus_be, bus_wdata,
      input  bus_gnt, bus_rvalid, bus_rdata
   );

   modport slave (
      input  bus_req, bus_addr, bus_we, bus_be, bus_wdata,
      output bus_gnt, bus_rvalid, bus_rdata
   );
endinterface

// File: rtl/cgra_mem_port_ctrl.sv
// Multi-channel CGRA data-memory port: pointer/indirect addressing, in-order tag
// tracking, posted writes and grouped stall. CGRA_MEM_PORT_STRIDE_EN enables stride_i.
module cgra_mem_port_ctrl #(
   parameter int N_CH    = 4,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MAX_OUT = 2
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [N_CH-1:0]             start_i,
   input  logic [N_CH-1:0][AW-1:0]     rd_base_i,
   input  logic [N_CH-1:0][AW-1:0]     wr_base_i,
   input  logic [N_CH-1:0][AW-1:0]     stride_i,
   input  logic [N_CH-1:0][N_CH-1:0]   grp_map_i,
   input  logic [N_CH-1:0]             req_i,
   input  logic [N_CH-1:0]             we_i,
   input  logic [N_CH-1:0]             ind_i,
   input  logic [N_CH-1:0][AW-1:0]     addr_i,
   input  logic [N_CH-1:0][DW-1:0]     wdata_i,
   input  logic [N_CH-1:0][DW/8-1:0]   be_i,
   cgra_mem_port_ctrl_if.master        bus,
   output logic [N_CH-1:0][DW-1:0]     rdata_o,
   output logic [N_CH-1:0]             rvalid_o,
   output logic [N_CH-1:0]             stall_o,
   output logic [N_CH-1:0]             err_o
);
   localparam int CW = $clog2(MAX_OUT + 1);
   localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

   logic [N_CH-1:0] w_raw_stall;

`ifndef CGRA_MEM_PORT_STRIDE_EN
   logic w_unused_stride;
   assign w_unused_stride = ^stride_i;
`endif

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      logic [AW-1:0]      r_rd_ptr, r_wr_ptr, w_step;
      logic [CW-1:0]      r_cnt, r_rpend;
      logic [MAX_OUT-1:0] r_tag;
      logic [PW-1:0]      r_head, r_tail;
      logic [DW-1:0]      r_rdata_q;
      logic               r_err;
      logic               w_full, w_acc, w_pop, w_pop_rd, w_push_rd;

`ifdef CGRA_MEM_PORT_STRIDE_EN
      assign w_step = stride_i[c];
`else
      assign w_step = AW'(DW / 8);
`endif

      // At full, a same-cycle response frees a slot so the request may still issue.
      assign w_full           = (r_cnt == CW'(MAX_OUT));
      assign bus.bus_req[c]   = req_i[c] & (~w_full | bus.bus_rvalid[c]);
      assign bus.bus_addr[c]  = ind_i[c] ? addr_i[c] : (we_i[c] ? r_wr_ptr : r_rd_ptr);
      assign bus.bus_we[c]    = we_i[c];
      assign bus.bus_be[c]    = be_i[c];
      assign bus.bus_wdata[c] = wdata_i[c];

      assign w_acc     = bus.bus_req[c] & bus.bus_gnt[c];
      assign w_pop     = bus.bus_rvalid[c] & (r_cnt != '0);
      assign w_pop_rd  = w_pop & ~r_tag[r_head];
      assign w_push_rd = w_acc & ~we_i[c];

      assign rvalid_o[c]    = w_pop_rd;
      assign rdata_o[c]     = w_pop_rd ? bus.bus_rdata[c] : r_rdata_q;
      assign err_o[c]       = r_err;
      assign w_raw_stall[c] = (req_i[c] & ~w_acc) | ((r_rpend != '0) & ~w_pop_rd);

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_cnt     <= '0;
            r_rpend   <= '0;
            r_tag     <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_rdata_q <= '0;
            r_err     <= 1'b0;
         end else begin
            if (start_i[c]) begin
               r_rd_ptr <= rd_base_i[c];
               r_wr_ptr <= wr_base_i[c];
            end else if (w_acc && !ind_i[c]) begin
               if (we_i[c]) r_wr_ptr <= r_wr_ptr + w_step;
               else         r_rd_ptr <= r_rd_ptr + w_step;
            end

            if (start_i[c])                                r_err <= 1'b0;
            else if (bus.bus_rvalid[c] && (r_cnt == '0))   r_err <= 1'b1;

            if (w_acc) begin
               r_tag[r_tail] <= we_i[c];
               r_tail        <= (r_tail == PW'(MAX_OUT - 1)) ? '0 : r_tail + PW'(1);
            end
            if (w_pop)
               r_head <= (r_head == PW'(MAX_OUT - 1)) ? '0 : r_head + PW'(1);

            if (w_acc && !w_pop)      r_cnt <= r_cnt + CW'(1);
            else if (!w_acc && w_pop) r_cnt <= r_cnt - CW'(1);

            if (w_push_rd && !w_pop_rd)      r_rpend <= r_rpend + CW'(1);
            else if (!w_push_rd && w_pop_rd) r_rpend <= r_rpend - CW'(1);

            if (w_pop_rd) r_rdata_q <= bus.bus_rdata[c];
         end
      end
   end

   always_comb begin
      stall_o = '0;
      for (int c = 0; c < N_CH; c++)
         stall_o[c] = |(grp_map_i[c] & w_raw_stall);
   end
endmodule
